// File: rtl/ksa_pipe_if.sv
// Operand/result handshake bundle for the pipelined Kogge-Stone add/subtract unit.
// master = producer+consumer side, slave = the arithmetic unit.
interface ksa_pipe_if #(
   parameter int N = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         zero;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero
   );
endinterface

// File: rtl/ksa_pipe.sv
// Pipelined Kogge-Stone add/subtract with carry-in, flags and a global-stall handshake.
// A register bank follows every LEVELS_PER_STAGE prefix levels and always the last one.
module ksa_pipe #(
   parameter int N                = 32,
   parameter int LEVELS_PER_STAGE = 2
) (
   input  logic       clk,
   input  logic       rst,
   ksa_pipe_if.slave  bus
);
   localparam int L = $clog2(N);
   localparam int D = (L + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

   logic         advance;
   logic [N-1:0] b_x;
   logic [N-1:0] g_raw;
   logic [N-1:0] g0;
   logic [N-1:0] p0;
   logic         c0;

   logic [N-1:0] g_in  [1:L];
   logic [N-1:0] p_in  [1:L];
   logic [N-1:0] g_out [1:L];
   logic [N-1:0] p_out [1:L];

   logic [N-1:0] g_bank     [0:D-1];
   logic [N-1:0] p_bank     [0:D-1];
   logic [N-1:0] porig_bank [0:D-1];
   logic         c0_bank    [0:D-1];
   logic         valid_bank [0:D-1];

   logic [N-1:0] g_final;
   logic [N-1:0] carry;
   logic [N-1:0] sum_int;

   // The whole pipe moves as one; a held result freezes every stage.
   assign advance      = !valid_bank[D-1] | bus.out_ready;
   assign bus.in_ready = advance;

   assign b_x   = bus.b ^ {N{bus.sub}};
   assign c0    = bus.sub | bus.cin;
   assign p0    = bus.a ^ b_x;
   assign g_raw = bus.a & b_x;
   // Carry-in becomes part of the bit-0 generate so the prefix tree needs no extra column.
   assign g0    = {g_raw[N-1:1], g_raw[0] | (p0[0] & c0)};

   generate
      for (genvar gi = 1; gi <= L; gi++) begin : g_level
         localparam int DIST = 1 << (gi - 1);

         if (gi == 1) begin : g_src_comb0
            assign g_in[gi] = g0;
            assign p_in[gi] = p0;
         end else if (((gi - 1) % LEVELS_PER_STAGE) == 0) begin : g_src_bank
            assign g_in[gi] = g_bank[(gi - 1) / LEVELS_PER_STAGE - 1];
            assign p_in[gi] = p_bank[(gi - 1) / LEVELS_PER_STAGE - 1];
         end else begin : g_src_prev
            assign g_in[gi] = g_out[gi - 1];
            assign p_in[gi] = p_out[gi - 1];
         end

         assign g_out[gi][DIST-1:0] = g_in[gi][DIST-1:0];
         assign p_out[gi][DIST-1:0] = p_in[gi][DIST-1:0];
         assign g_out[gi][N-1:DIST] = g_in[gi][N-1:DIST]
                                    | (p_in[gi][N-1:DIST] & g_in[gi][N-1-DIST:0]);
         assign p_out[gi][N-1:DIST] = p_in[gi][N-1:DIST] & p_in[gi][N-1-DIST:0];
      end

      for (genvar gi = 0; gi < D; gi++) begin : g_stage
         localparam int LV = ((gi + 1) * LEVELS_PER_STAGE > L) ? L : (gi + 1) * LEVELS_PER_STAGE;

         logic [N-1:0] g_reg;
         logic [N-1:0] p_reg;
         logic [N-1:0] porig_reg;
         logic         c0_reg;
         logic         valid_reg;
         logic [N-1:0] porig_next;
         logic         c0_next;
         logic         valid_next;

         if (gi == 0) begin : g_first
            assign porig_next = p0;
            assign c0_next    = c0;
            assign valid_next = bus.in_valid;
         end else begin : g_chain
            assign porig_next = porig_bank[gi - 1];
            assign c0_next    = c0_bank[gi - 1];
            assign valid_next = valid_bank[gi - 1];
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               g_reg     <= '0;
               p_reg     <= '0;
               porig_reg <= '0;
               c0_reg    <= 1'b0;
               valid_reg <= 1'b0;
            end else if (advance) begin
               g_reg     <= g_out[LV];
               p_reg     <= p_out[LV];
               porig_reg <= porig_next;
               c0_reg    <= c0_next;
               valid_reg <= valid_next;
            end
         end

         assign g_bank[gi]     = g_reg;
         assign p_bank[gi]     = p_reg;
         assign porig_bank[gi] = porig_reg;
         assign c0_bank[gi]    = c0_reg;
         assign valid_bank[gi] = valid_reg;
      end
   endgenerate

   assign g_final = g_bank[D-1];
   assign carry   = {g_final[N-2:0], c0_bank[D-1]};
   assign sum_int = porig_bank[D-1] ^ carry;

   assign bus.out_valid = valid_bank[D-1];
   assign bus.sum       = sum_int;
   assign bus.cout      = g_final[N-1];
   assign bus.ovf       = carry[N-1] ^ g_final[N-1];
   assign bus.zero      = ~|sum_int;
endmodule
